ifu_fetch: RTL

Instruction fetch stage that sits directly upstream of the decode unit (idu) in the NPC core.
- Owns the architectural fetch PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers returned instructions in a small FIFO and presents {pc, inst, fault} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute, discarding in-flight and buffered wrong-path fetches.

---
 rtl/ifu_fetch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch stage; one outstanding imem request, small
//            output FIFO towards decode, redirect flush with wrong-path drop.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HALT = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [63:0]     req_pc_q, req_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     fifo_pc_q    [FIFO_DEPTH];
    logic [63:0]     fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q  [FIFO_DEPTH];
    logic [31:0]     fifo_inst_d  [FIFO_DEPTH];
    logic            fifo_fault_q [FIFO_DEPTH];
    logic            fifo_fault_d [FIFO_DEPTH];

    logic w_hs;
    logic w_push;
    logic w_pop;
    logic w_unused_bits;

    assign w_unused_bits  = ^redirect_pc[1:0];
    assign imem_req_valid = (state_q == ST_REQ) && (count_q < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign w_hs           = imem_req_valid && imem_req_ready;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign out_inst  = fifo_inst_q[rd_ptr_q];
    assign out_fault = fifo_fault_q[rd_ptr_q];
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        w_push   = 1'b0;
        if (redirect_valid) begin
            pc_d = {redirect_pc[63:2], 2'b00};
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_REQ:  state_d = w_hs ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
                ST_HALT: state_d = ST_REQ;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (w_hs) begin
                        pc_d     = pc_q + 64'd4;
                        req_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        w_push  = 1'b1;
                        state_d = imem_resp_err ? ST_HALT : ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_d = ST_REQ;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Request gating on count keeps push away from a full FIFO, so no overflow check here.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_inst_d  = fifo_inst_q;
        fifo_fault_d = fifo_fault_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                fifo_pc_d[wr_ptr_q]    = req_pc_q;
                fifo_inst_d[wr_ptr_q]  = imem_resp_data;
                fifo_fault_d[wr_ptr_q] = imem_resp_err;
                wr_ptr_d               = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_inst_q[i]  <= '0;
                fifo_fault_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_inst_q  <= fifo_inst_d;
            fifo_fault_q <= fifo_fault_d;
        end
    end

endmodule
`default_nettype wire
